// File: rtl/i_softmax_norm_pkg.sv
// rtl/i_softmax_norm_pkg.sv - shared widths, constants and state type for the softmax normalizer
package softmax_pkg;
  localparam int DEF_VEC_LEN = 8;

  // Sum of up to n non-negative 32-bit elements needs 32 + clog2(n) bits
  function automatic int sum_width(input int n);
    return 32 + $clog2(n);
  endfunction

  localparam int          SUM_W       = sum_width(DEF_VEC_LEN);
  localparam int          RECIP_NUM_W = 33;
  localparam logic [31:0] FACTOR_SAT  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {LOAD, DIV, OUT} state_t;
endpackage

// File: rtl/i_softmax_norm_if.sv
// rtl/i_softmax_norm_if.sv - input/output stream bundle of the softmax normalizer
interface i_softmax_norm_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/i_softmax_norm_div.sv
// rtl/i_softmax_norm_div.sv - sequential restoring reciprocal: quotient = floor(2^32 / divisor), saturated
module seq_recip_div
  import softmax_pkg::*;
#(
  parameter int DIV_W = SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [31:0]      quotient
);
  localparam int CNT_W = $clog2(RECIP_NUM_W + 1);

  logic [DIV_W-1:0]       dvsr;
  logic [DIV_W-1:0]       rem;
  logic [RECIP_NUM_W-1:0] q;
  logic [CNT_W-1:0]       cnt;
  logic                   running;
  logic [DIV_W:0]         trial;
  logic                   fits;

  // The dividend 2^32 is a single 1 followed by zeros, so only the first step shifts in a 1
  always_comb begin
    trial = {rem, (cnt == CNT_W'(RECIP_NUM_W))};
    fits  = (trial >= {1'b0, dvsr});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvsr    <= '0;
      rem     <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dvsr    <= divisor;
        rem     <= '0;
        q       <= '0;
        cnt     <= CNT_W'(RECIP_NUM_W);
        running <= 1'b1;
      end else if (running) begin
        rem <= fits ? DIV_W'(trial - {1'b0, dvsr}) : trial[DIV_W-1:0];
        q   <= {q[RECIP_NUM_W-2:0], fits};
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  // Quotient bit 32 is set only for divisor 1; divisor 0 yields all ones anyway
  assign quotient = (q[RECIP_NUM_W-1] || (dvsr == '0)) ? FACTOR_SAT : q[31:0];
endmodule

// File: rtl/i_softmax_norm.sv
// rtl/i_softmax_norm.sv - buffers one row of exp values, divides 2^32 by their sum, streams scaled probabilities
module i_softmax_norm
  import softmax_pkg::*;
#(
  parameter int VEC_LEN  = DEF_VEC_LEN,
  parameter int OUT_BITS = 8,
  parameter int DATA_W   = 32
) (
  input logic              clk,
  input logic              rst_n,
  i_softmax_norm_if.slave  bus
);
  localparam int SW    = sum_width(VEC_LEN);
  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int SHIFT = 32 - OUT_BITS;

  state_t            state;
  logic [DATA_W-1:0] buf_mem [VEC_LEN];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  rd;
  logic [SW-1:0]     sum;
  logic [SW-1:0]     sum_next;
  logic [31:0]       factor;
  logic [31:0]       quotient;
  logic [31:0]       elem;
  logic              hs;
  logic              close_row;
  logic              div_done;
  logic [63:0]       prod;

  always_comb begin
    elem      = bus.in_data[31] ? 32'd0 : bus.in_data;
    hs        = bus.in_valid && bus.in_ready;
    close_row = hs && (bus.in_last || (count == CNT_W'(VEC_LEN - 1)));
    sum_next  = sum + SW'(elem);
  end

  always_ff @(posedge clk) begin
    if (hs) buf_mem[count[IDX_W-1:0]] <= elem;
  end

  // The divisor is the sum including the closing element, so the divider starts on that same edge
  seq_recip_div #(.DIV_W(SW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (close_row),
    .divisor  (sum_next),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      count         <= '0;
      sum           <= '0;
      factor        <= '0;
      rd            <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (hs) begin
            sum   <= sum_next;
            count <= count + CNT_W'(1);
            if (close_row) begin
              state        <= DIV;
              bus.in_ready <= 1'b0;
              bus.busy     <= 1'b1;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            state         <= OUT;
            factor        <= quotient;
            rd            <= '0;
            bus.out_valid <= 1'b1;
            bus.out_last  <= (count == CNT_W'(1));
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            if (bus.out_last) begin
              state         <= LOAD;
              count         <= '0;
              sum           <= '0;
              rd            <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.busy      <= 1'b0;
              bus.in_ready  <= 1'b1;
            end else begin
              rd           <= rd + CNT_W'(1);
              bus.out_last <= ((rd + CNT_W'(2)) == count);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Element <= sum, so the scaled product never exceeds 2^OUT_BITS
  assign prod         = 64'(buf_mem[rd[IDX_W-1:0]]) * 64'(factor);
  assign bus.out_data = bus.out_valid ? 32'(prod >> SHIFT) : 32'd0;
endmodule

// File: tb/tb_i_softmax_norm.sv
// tb/tb_i_softmax_norm.sv - scoreboard bench for the softmax normalizer
module tb_i_softmax_norm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i_softmax_norm_if bus();

  i_softmax_norm #(.VEC_LEN(8), .OUT_BITS(8), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  int          passed = 0;
  int          total  = 0;
  exp_t        sb[$];
  logic [31:0] obs_d[$];
  logic        obs_l[$];
  logic [31:0] row_v[$];

  function automatic logic [31:0] model_out(input logic [31:0] x, input logic [63:0] s);
    logic [63:0] f;
    logic [63:0] xc;
    xc = x[31] ? 64'd0 : {32'd0, x};
    if (s == 0) f = 64'hFFFF_FFFF;
    else begin
      f = 64'h1_0000_0000 / s;
      if (f > 64'hFFFF_FFFF) f = 64'hFFFF_FFFF;
    end
    return 32'((xc * f) >> 24);
  endfunction

  task automatic send(input logic [31:0] d, input logic l);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      total++;
      $display("FAIL send_timeout waited=%0d cycles, in_ready never rose", g);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Pushes expectations for the whole row, then drives it; last flag only on the final element
  task automatic push_row(input bit with_last);
    logic [63:0] s = 0;
    int n = row_v.size();
    foreach (row_v[i]) s += row_v[i][31] ? 64'd0 : {32'd0, row_v[i]};
    for (int i = 0; i < n; i++) sb.push_back(exp_t'{model_out(row_v[i], s), (i == n - 1)});
    for (int i = 0; i < n; i++) send(row_v[i], with_last && (i == n - 1));
  endtask

  task automatic collect(input int n);
    int got = 0;
    int guard = 0;
    bus.out_ready = 1'b1;
    while (got < n && guard < 300) begin
      if (bus.out_valid) begin
        obs_d.push_back(bus.out_data);
        obs_l.push_back(bus.out_last);
        got++;
      end
      @(negedge clk);
      guard++;
    end
    total++;
    if (got != n) $display("FAIL collect_count got=%0d need=%0d", got, n);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b need=1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b need=0", bus.out_valid); else passed++;
    total++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got=%b need=0", bus.out_last); else passed++;
    total++; if (bus.out_data !== 32'd0) $display("FAIL reset_out_data got=%0h need=0", bus.out_data); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b need=0", bus.busy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_row4();
    exp_t e;
    int lat = 0;
    row_v = '{100, 100, 100, 100};
    push_row(1'b1);
    total++; if (bus.busy !== 1'b1) $display("FAIL row4_busy got=%b need=1", bus.busy); else passed++;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat != 34) $display("FAIL row4_latency got=%0d need=34", lat); else passed++;
    collect(4);
    while (obs_d.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_d[0] !== e.data || obs_l[0] !== e.last || obs_d[0] !== 32'd63)
        $display("FAIL row4_out got=%0d/%b need=%0d/%b", obs_d[0], obs_l[0], e.data, e.last);
      else passed++;
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
    end
    total++; if (bus.in_ready !== 1'b1) $display("FAIL row4_in_ready_after got=%b need=1", bus.in_ready); else passed++;
  endtask

  task automatic test_single();
    exp_t e;
    row_v = '{1000}; push_row(1'b1); collect(1);
    row_v = '{1};    push_row(1'b1); collect(1);
    row_v = '{0, 0}; push_row(1'b1); collect(2);
    while (obs_d.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_d[0] !== e.data || obs_l[0] !== e.last)
        $display("FAIL single_out got=%0d/%b need=%0d/%b", obs_d[0], obs_l[0], e.data, e.last);
      else passed++;
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [31:0] hold_d;
    int g = 0;
    row_v = '{1000, 3000};
    push_row(1'b1);
    bus.out_ready = 1'b1;
    while (!bus.out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    obs_d.push_back(bus.out_data); obs_l.push_back(bus.out_last);
    @(negedge clk);
    bus.out_ready = 1'b0;
    hold_d = bus.out_data;
    total++; if (bus.out_data !== sb[1].data || bus.out_last !== 1'b1)
      $display("FAIL bp_stall1 got=%0d/%b need=%0d/1", bus.out_data, bus.out_last, sb[1].data); else passed++;
    @(negedge clk);
    total++; if (bus.out_data !== hold_d || bus.out_last !== 1'b1 || bus.out_valid !== 1'b1)
      $display("FAIL bp_stall2 got=%0d/%b need=%0d/1", bus.out_data, bus.out_last, hold_d); else passed++;
    @(negedge clk);
    bus.out_ready = 1'b1;
    obs_d.push_back(bus.out_data); obs_l.push_back(bus.out_last);
    @(negedge clk);
    while (obs_d.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_d[0] !== e.data || obs_l[0] !== e.last)
        $display("FAIL bp_out got=%0d/%b need=%0d/%b", obs_d[0], obs_l[0], e.data, e.last);
      else passed++;
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
    end
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_row_done got valid=%b ready=%b need 0/1", bus.out_valid, bus.in_ready); else passed++;
  endtask

  task automatic test_forced_last();
    exp_t e;
    row_v.delete();
    repeat (8) row_v.push_back(32'd10);
    push_row(1'b0);
    total++; if (bus.in_ready !== 1'b0) $display("FAIL forced_in_ready got=%b need=0", bus.in_ready); else passed++;
    sb.push_back(exp_t'{model_out(32'd10, 64'd40), 1'b0});
    sb.push_back(exp_t'{model_out(32'd30, 64'd40), 1'b1});
    fork
      send(32'd10, 1'b0);
      collect(8);
    join
    send(32'd30, 1'b1);
    collect(2);
    while (obs_d.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_d[0] !== e.data || obs_l[0] !== e.last)
        $display("FAIL forced_out got=%0d/%b need=%0d/%b", obs_d[0], obs_l[0], e.data, e.last);
      else passed++;
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
    end
  endtask

  task automatic test_reset_mid_div();
    exp_t e;
    int seen = 0;
    send(32'd500, 1'b1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
                 bus.out_last !== 1'b0 || bus.out_data !== 32'd0)
      $display("FAIL abort_reset_outputs got ready=%b busy=%b valid=%b last=%b data=%0h need 1/0/0/0/0",
               bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.out_data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    row_v = '{50};
    push_row(1'b1);
    collect(1);
    while (obs_d.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_d[0] !== e.data || obs_l[0] !== e.last || obs_d[0] !== 32'd255)
        $display("FAIL abort_next_row got=%0d/%b need=%0d/%b", obs_d[0], obs_l[0], e.data, e.last);
      else passed++;
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
    end
    repeat (40) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) $display("FAIL abort_residue got=%0d extra valid cycles need=0", seen); else passed++;
  endtask

  task automatic test_negative();
    exp_t e;
    row_v = '{32'h8000_0005, 200};
    push_row(1'b1);
    collect(2);
    while (obs_d.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_d[0] !== e.data || obs_l[0] !== e.last)
        $display("FAIL negative_out got=%0d/%b need=%0d/%b", obs_d[0], obs_l[0], e.data, e.last);
      else passed++;
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_row4();
    test_single();
    test_backpressure();
    test_forced_last();
    test_reset_mid_div();
    test_negative();
    total++; if (sb.size() != 0) $display("FAIL scoreboard_leftover got=%0d need=0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/i_softmax_norm.md
Name: i_softmax_norm

Overview:
- Downstream consumer of the integer-exp stage (I_EXP) in the integer softmax path.
- Collects one row of non-negative exp values and accumulates their sum.
- Computes factor = floor(2^32 / sum) with a sequential restoring divider.
- Streams out normalized values out = (x * factor) >> (32 - OUT_BITS), i.e. softmax probabilities scaled by 2^OUT_BITS.

Parameters:
- VEC_LEN, 8: maximum elements per row; buffer depth.
- OUT_BITS, 8: output probability precision; legal range 1..31.
- DATA_W, 32: element width; fixed at 32, matching the exp stage.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  32  exp value, signed two's complement.
- in_last  in  1  marks the final element of a row.
- out_valid  out  1  normalized element valid.
- out_ready  in  1  downstream accepts the element.
- out_data  out  32  normalized value, zero-extended, range 0..2^OUT_BITS.
- out_last  out  1  marks the final normalized element of the row.
- busy  out  1  high in DIV and OUT states.

Behaviour:
- Reset: asynchronous, active-low. Returns state to LOAD, clears count, sum, factor and read pointer. Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0. Reset mid-row or mid-division discards the row; no partial output appears afterwards.
- States:
  - LOAD: in_ready=1. A handshake (in_valid & in_ready) writes the clamped element to buf[count], adds it to sum (width 32+clog2(VEC_LEN), no overflow possible), and increments count.
  - Clamp: if in_data[31] is set, the element is stored as 0.
  - LOAD -> DIV: when the handshake carries in_last=1, or when count reaches VEC_LEN (forced last; the VEC_LEN-th element closes the row).
  - DIV: in_ready=0, busy=1. Restoring division of 2^32 (33-bit dividend) by sum, one quotient bit per cycle, 33 cycles. If the quotient is >= 2^32 (only when sum=1) or sum=0, factor = 32'hFFFF_FFFF.
  - DIV -> OUT: after the final quotient bit.
  - OUT: out_valid=1. out_data = (buf[rd] * factor)[63:0] >> (32 - OUT_BITS), low 32 bits. out_last=1 when rd = count-1. Each out handshake increments rd. Handshake on the last element -> LOAD; count, sum and rd clear. in_ready returns to 1 the next cycle.
- Latency: first out_valid rises exactly 34 cycles after the in_last handshake edge. Throughput in OUT is one element per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Rows never overlap. Input is stalled (in_ready=0) for the whole of DIV and OUT.
- Multiply: 32x32 unsigned, combinational from the buffer and factor registers. Because x <= sum, the result never exceeds 2^OUT_BITS; no saturation logic is needed.
- Single-element row (count=1) is legal. An in_last handshake always closes the current row, including a zero-valued one.

Decomposition:
- Shared package softmax_pkg holds:
  - SUM_W = 32 + clog2(VEC_LEN);
  - RECIP_NUM_W = 33;
  - FACTOR_SAT = 32'hFFFF_FFFF;
  - the state enum {LOAD, DIV, OUT}.
- One sub-module: seq_recip_div.
  - Start/done handshake, 33-cycle restoring divider of 2^32 by a SUM_W divisor.
  - Outputs a saturated 32-bit quotient.
  - Also reusable by the layernorm path.
- Buffer, FSM and output multiply stay in i_softmax_norm.

Test Plan:
- Row {100,100,100,100, last on 4th}, out_ready=1:
  - sum=400, factor=10737418.
  - Four outputs of 63; out_last on the 4th only.
  - First out_valid 34 cycles after the last input.
- Single element 1000 with last:
  - factor=4294967, output 255.
- Single element 1 with last:
  - factor saturates to FFFF_FFFF, output 255.
  - Row {0,0,last}: two outputs of 0, no X.
- Row {1000,3000, last}, out_ready toggled 1,0,0,1:
  - sum=4000, factor=1073741.
  - Outputs 63 then 191, each held stable through the stall cycles.
- Nine elements of value 10, no in_last:
  - 8th element forces last; in_ready=0 after it.
  - Eight outputs of 31 with out_last on the 8th.
  - 9th element is accepted only after the row completes, as a new row.
- Reset asserted on the 10th DIV cycle:
  - All outputs return to reset values immediately.
  - Next row {50,last} yields 255 with no residue from the aborted row.
- Negative input 32'h8000_0005 in row {negative, 200, last}:
  - Outputs 0 then 255.
